// File: rtl/multicycle_mainfsm.sv
// Main control FSM for the multicycle ARM datapath with a memory-ready handshake.
// Optional feature macro MAINFSM_UNDEF_TRAP_EN: undefined ops (Op=11) trap with an Undef flag.
module multicycle_mainfsm #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         Op,
   input  logic [5:0]         Funct,
   input  logic               MemReady,
   output logic               IRWrite,
   output logic               NextPC,
   output logic               RegW,
   output logic               MemW,
   output logic               Branch,
   output logic               ALUOp,
   output logic               AdrSrc,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ResultSrc,
   output logic [STATE_W-1:0] State
`ifdef MAINFSM_UNDEF_TRAP_EN
   ,
   output logic               Undef
`endif
);

   typedef enum logic [STATE_W-1:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      TRAP     = 4'd10
   } state_e;

   state_e state_r;
   state_e next_state_s;
   logic   unused_funct_s;

   assign unused_funct_s = ^Funct[4:1];
   assign State          = state_r;

   // State register; reset drops straight back to FETCH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      next_state_s = FETCH;
      case (state_r)
         FETCH: begin
            if (MemReady) begin
               next_state_s = DECODE;
            end else begin
               next_state_s = FETCH;
            end
         end
         DECODE: begin
            case (Op)
               2'b00: begin
                  if (Funct[5]) begin
                     next_state_s = EXECUTEI;
                  end else begin
                     next_state_s = EXECUTER;
                  end
               end
               2'b01:   next_state_s = MEMADR;
               2'b10:   next_state_s = BRANCH;
`ifdef MAINFSM_UNDEF_TRAP_EN
               2'b11:   next_state_s = TRAP;
`else
               2'b11:   next_state_s = FETCH;
`endif
               default: next_state_s = FETCH;
            endcase
         end
         MEMADR: begin
            if (Funct[0]) begin
               next_state_s = MEMREAD;
            end else begin
               next_state_s = MEMWRITE;
            end
         end
         MEMREAD: begin
            if (MemReady) begin
               next_state_s = MEMWB;
            end else begin
               next_state_s = MEMREAD;
            end
         end
         MEMWRITE: begin
            if (MemReady) begin
               next_state_s = FETCH;
            end else begin
               next_state_s = MEMWRITE;
            end
         end
         EXECUTER: next_state_s = ALUWB;
         EXECUTEI: next_state_s = ALUWB;
         MEMWB:    next_state_s = FETCH;
         ALUWB:    next_state_s = FETCH;
         BRANCH:   next_state_s = FETCH;
`ifdef MAINFSM_UNDEF_TRAP_EN
         TRAP:     next_state_s = TRAP;
`endif
         default:  next_state_s = FETCH;
      endcase
   end

   // Moore output decode; fetch strobes also wait on MemReady and are held off during reset.
   always_comb begin
      IRWrite   = 1'b0;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      ALUOp     = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
`ifdef MAINFSM_UNDEF_TRAP_EN
      Undef     = 1'b0;
`endif
      case (state_r)
         FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = MemReady & reset;
            NextPC    = MemReady & reset;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         MEMADR: begin
            ALUSrcB   = 2'b01;
         end
         MEMREAD: begin
            AdrSrc    = 1'b1;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            RegW      = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc    = 1'b1;
            MemW      = 1'b1;
         end
         EXECUTER: begin
            ALUOp     = 1'b1;
         end
         EXECUTEI: begin
            ALUSrcB   = 2'b01;
            ALUOp     = 1'b1;
         end
         ALUWB: begin
            RegW      = 1'b1;
         end
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            Branch    = 1'b1;
         end
`ifdef MAINFSM_UNDEF_TRAP_EN
         TRAP: begin
            Undef     = 1'b1;
         end
`endif
         default: begin
            IRWrite   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_mainfsm.sv
// Directed bench for multicycle_mainfsm; expected output words are hand-written per state.
module tb_multicycle_mainfsm;

   logic       clk;
   logic       reset;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       MemReady;
   logic       IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, ALUSrcA;
   logic [1:0] ALUSrcB, ResultSrc;
   logic [3:0] State;
`ifdef MAINFSM_UNDEF_TRAP_EN
   logic       Undef;
`endif

   int n_cmp;
   int n_bad;

   multicycle_mainfsm #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
      .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
      .ALUOp(ALUOp), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .State(State)
`ifdef MAINFSM_UNDEF_TRAP_EN
      , .Undef(Undef)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word layout: {State, IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}
   logic [15:0] obs_vec;
   assign obs_vec = {State, IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc};

   localparam logic [15:0] E_RST   = {4'd0,  5'b00000, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10};
   localparam logic [15:0] E_FETCH = {4'd0,  5'b11000, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10};
   localparam logic [15:0] E_DEC   = {4'd1,  5'b00000, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10};
   localparam logic [15:0] E_MADR  = {4'd2,  5'b00000, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
   localparam logic [15:0] E_MRD   = {4'd3,  5'b00000, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
   localparam logic [15:0] E_MWB   = {4'd4,  5'b00100, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01};
   localparam logic [15:0] E_MWR   = {4'd5,  5'b00010, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
   localparam logic [15:0] E_EXR   = {4'd6,  5'b00000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
   localparam logic [15:0] E_EXI   = {4'd7,  5'b00000, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00};
   localparam logic [15:0] E_ALUWB = {4'd8,  5'b00100, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
   localparam logic [15:0] E_BR    = {4'd9,  5'b00001, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10};
   localparam logic [15:0] E_TRAP  = {4'd10, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp(input string tag, input logic [15:0] exp);
      #1;
      check(tag, {16'd0, obs_vec}, {16'd0, exp});
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0; MemReady = 1'b1; Op = 2'b00; Funct = 6'b000000;

      for (int i = 0; i < 3; i++) begin
         tick(); samp("reset_hold", E_RST);
      end
      tick(); reset = 1'b1; samp("release_fetch", E_FETCH);

      // data-processing register: 0,1,6,8,0
      tick(); samp("dp_decode", E_DEC);
      tick(); samp("dp_execr", E_EXR);
      tick(); samp("dp_aluwb", E_ALUWB);
      tick(); Op = 2'b01; Funct = 6'b100001; samp("ldr_fetch", E_FETCH);

      // load: 0,1,2,3,4,0
      tick(); samp("ldr_decode", E_DEC);
      tick(); samp("ldr_memadr", E_MADR);
      tick(); samp("ldr_memread", E_MRD);
      tick(); samp("ldr_memwb", E_MWB);
      tick(); Funct = 6'b100000; samp("str_fetch", E_FETCH);

      // store with three not-ready cycles in MEMWRITE
      tick(); samp("str_decode", E_DEC);
      tick(); samp("str_memadr", E_MADR);
      tick(); MemReady = 1'b0; samp("str_wait0", E_MWR);
      tick(); samp("str_wait1", E_MWR);
      tick(); samp("str_wait2", E_MWR);
      tick(); MemReady = 1'b1; samp("str_done", E_MWR);

      // fetch stall for two cycles, then branch
      tick(); MemReady = 1'b0; samp("fetch_stall0", E_RST);
      tick(); samp("fetch_stall1", E_RST);
      tick(); MemReady = 1'b1; Op = 2'b10; samp("fetch_ready", E_FETCH);
      tick(); samp("br_decode", E_DEC);
      tick(); samp("br_branch", E_BR);
      tick(); Op = 2'b01; Funct = 6'b000001; samp("br_back", E_FETCH);

      // load with a MEMREAD stall
      tick(); samp("ldw_decode", E_DEC);
      tick(); samp("ldw_memadr", E_MADR);
      tick(); MemReady = 1'b0; samp("ldw_read0", E_MRD);
      tick(); samp("ldw_read1", E_MRD); MemReady = 1'b1;
      tick(); samp("ldw_memwb", E_MWB);
      tick(); Op = 2'b00; Funct = 6'b100000; samp("exi_fetch", E_FETCH);

      // immediate DP; Op change during execute must not matter
      tick(); samp("exi_decode", E_DEC);
      tick(); Op = 2'b10; samp("exi_execi", E_EXI);
      tick(); samp("exi_aluwb", E_ALUWB);
      tick(); Op = 2'b11; samp("undef_fetch", E_FETCH);
      tick(); samp("undef_decode", E_DEC);

`ifdef MAINFSM_UNDEF_TRAP_EN
      for (int i = 0; i < 10; i++) begin
         tick(); samp("trap_hold", E_TRAP);
         check("trap_undef", {31'd0, Undef}, 32'd1);
      end
      reset = 1'b0; samp("trap_reset", E_RST);
      check("trap_undef_clr", {31'd0, Undef}, 32'd0);
      tick(); reset = 1'b1; Op = 2'b00; Funct = 6'b000000; samp("trap_release", E_FETCH);
`else
      tick(); Op = 2'b00; Funct = 6'b000000; samp("undef_nop", E_FETCH);
`endif

      // reset mid-instruction abandons the sequence
      tick(); samp("mid_decode", E_DEC);
      tick(); samp("mid_execr", E_EXR);
      reset = 1'b0; samp("mid_reset", E_RST);
      tick(); samp("mid_reset_hold", E_RST);
      reset = 1'b1; samp("mid_release", E_FETCH);
      tick(); samp("mid_decode2", E_DEC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
